// File: rtl/mem_test_monitor.sv
// mem_test_monitor: on-chip self-check for the MIPS top.
// Snoops data-memory writes, captures result words, waits for the done flag,
// then compares the captured words against expected values one per cycle.
module mem_test_monitor #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int ADDR_FLAG   = 320,
  parameter int ADDR_RESULT = 321,
  parameter int N_RESULTS   = 4,
  parameter int TIMEOUT_CLK = 20000,
  parameter int CNT_W       = 16
) (
  input  logic                        i_clk,
  input  logic                        i_arst_n,
  input  logic                        i_start,
  input  logic                        i_we,
  input  logic [ADDR_W-1:0]           i_addr,
  input  logic [DATA_W-1:0]           i_wdata,
  input  logic [N_RESULTS*DATA_W-1:0] i_exp_data,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_pass,
  output logic                        o_timeout,
  output logic [3:0]                  o_fail_idx,
  output logic [DATA_W-1:0]           o_result0,
  output logic [CNT_W-1:0]            o_cycles
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_PASS  = 3'd3;
  localparam logic [2:0] S_FAIL  = 3'd4;
  localparam logic [2:0] S_TOUT  = 3'd5;

  localparam int              VEC_W    = N_RESULTS * DATA_W;
  localparam logic [ADDR_W-1:0] FLAG_A = ADDR_W'(ADDR_FLAG);
  localparam logic [ADDR_W-1:0] RES_A  = ADDR_W'(ADDR_RESULT);
  localparam logic [ADDR_W-1:0] RES_N  = ADDR_W'(N_RESULTS);
  localparam logic [CNT_W-1:0]  TOUT_LIM = CNT_W'(TIMEOUT_CLK - 1);
  localparam logic [3:0]        LAST_IDX = 4'(N_RESULTS - 1);

  logic [2:0]           state_q,    state_d;
  logic [VEC_W-1:0]     exp_q,      exp_d;
  logic [VEC_W-1:0]     res_q,      res_d;
  logic [N_RESULTS-1:0] valid_q,    valid_d;
  logic [CNT_W-1:0]     cycles_q,   cycles_d;
  logic [3:0]           fail_idx_q, fail_idx_d;
  logic [3:0]           chk_idx_q,  chk_idx_d;

  logic [ADDR_W-1:0] addr_off;
  logic              res_hit;
  logic              flag_hit;
  logic [DATA_W-1:0] sel_res;
  logic [DATA_W-1:0] sel_exp;
  logic              sel_valid;
  logic              mismatch;

  // Decode the snooped write: result window hit and done-flag (value 1) hit.
  always_comb begin
    addr_off = i_addr - RES_A;
    res_hit  = i_we && (i_addr >= RES_A) && (addr_off < RES_N);
    flag_hit = i_we && (i_addr == FLAG_A) && (i_wdata == DATA_W'(1));
  end

  // Select the captured word, its valid bit and its expected word at the check index.
  always_comb begin
    sel_res   = '0;
    sel_exp   = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < N_RESULTS; k++) begin
      if (chk_idx_q == 4'(k)) begin
        sel_res   = res_q[k*DATA_W +: DATA_W];
        sel_exp   = exp_q[k*DATA_W +: DATA_W];
        sel_valid = valid_q[k];
      end
    end
    mismatch = !sel_valid || (sel_res != sel_exp);
  end

  // Next-state logic: arming, capture, flag/timeout detection and word-by-word check.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    res_d      = res_q;
    valid_d    = valid_q;
    cycles_d   = cycles_q;
    fail_idx_d = fail_idx_q;
    chk_idx_d  = chk_idx_q;
    case (state_q)
      S_IDLE, S_PASS, S_FAIL, S_TOUT: begin
        if (i_start) begin
          state_d    = S_RUN;
          exp_d      = i_exp_data;
          valid_d    = '0;
          cycles_d   = '0;
          fail_idx_d = '0;
        end
      end
      S_RUN: begin
        if (res_hit) begin
          for (int k = 0; k < N_RESULTS; k++) begin
            if (addr_off == ADDR_W'(k)) begin
              res_d[k*DATA_W +: DATA_W] = i_wdata;
              valid_d[k]                = 1'b1;
            end
          end
        end
        if (flag_hit) begin
          state_d   = S_CHECK;
          chk_idx_d = '0;
        end else if (cycles_q == TOUT_LIM) begin
          state_d = S_TOUT;
        end else if (cycles_q != '1) begin
          cycles_d = cycles_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          state_d    = S_FAIL;
          fail_idx_d = chk_idx_q;
        end else if (chk_idx_q == LAST_IDX) begin
          state_d = S_PASS;
        end else begin
          chk_idx_d = chk_idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q    <= S_IDLE;
      exp_q      <= '0;
      res_q      <= '0;
      valid_q    <= '0;
      cycles_q   <= '0;
      fail_idx_q <= '0;
      chk_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      res_q      <= res_d;
      valid_q    <= valid_d;
      cycles_q   <= cycles_d;
      fail_idx_q <= fail_idx_d;
      chk_idx_q  <= chk_idx_d;
    end
  end

  // Status outputs decoded from state; result word 0 reads as 0 until written.
  always_comb begin
    o_busy     = (state_q == S_RUN) || (state_q == S_CHECK);
    o_done     = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TOUT);
    o_pass     = (state_q == S_PASS);
    o_timeout  = (state_q == S_TOUT);
    o_fail_idx = fail_idx_q;
    o_result0  = valid_q[0] ? res_q[DATA_W-1:0] : '0;
    o_cycles   = cycles_q;
  end

endmodule

// File: tb/tb_mem_test_monitor.sv
// tb_mem_test_monitor: directed self-checking bench for mem_test_monitor.
// A default instance covers pass/fail/filter/restart/reset; a second instance
// with a 50-cycle timeout covers the timeout boundary.
module tb_mem_test_monitor;

  logic          clk;
  logic          arst_n;
  logic          start_m;
  logic          start_t;
  logic          we;
  logic [9:0]    addr;
  logic [31:0]   wdata;
  logic [127:0]  exp_data;

  logic          m_busy, m_done, m_pass, m_tout;
  logic [3:0]    m_fidx;
  logic [31:0]   m_res0;
  logic [15:0]   m_cyc;

  logic          t_busy, t_done, t_pass, t_tout;
  logic [3:0]    t_fidx;
  logic [31:0]   t_res0;
  logic [15:0]   t_cyc;

  int errors = 0;
  int checks = 0;

  mem_test_monitor dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_start(start_m), .i_we(we),
    .i_addr(addr), .i_wdata(wdata), .i_exp_data(exp_data),
    .o_busy(m_busy), .o_done(m_done), .o_pass(m_pass), .o_timeout(m_tout),
    .o_fail_idx(m_fidx), .o_result0(m_res0), .o_cycles(m_cyc)
  );

  mem_test_monitor #(.TIMEOUT_CLK(50)) dut_t (
    .i_clk(clk), .i_arst_n(arst_n), .i_start(start_t), .i_we(we),
    .i_addr(addr), .i_wdata(wdata), .i_exp_data(exp_data),
    .o_busy(t_busy), .o_done(t_done), .o_pass(t_pass), .o_timeout(t_tout),
    .o_fail_idx(t_fidx), .o_result0(t_res0), .o_cycles(t_cyc)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge, settling 1 ns past it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One snooped memory write lasting a single cycle.
  task automatic applyStimulus(input logic [9:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick(1);
    we = 1'b0; addr = '0; wdata = '0;
  endtask

  // Pulse start on the chosen instance (0 = default, 1 = short timeout).
  task automatic pulseStart(input bit which);
    if (which) start_t = 1'b1; else start_m = 1'b1;
    tick(1);
    start_t = 1'b0; start_m = 1'b0;
  endtask

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Directed sequence covering every behaviour in turn.
  initial begin
    arst_n = 1'b0; start_m = 1'b0; start_t = 1'b0;
    we = 1'b0; addr = '0; wdata = '0;
    exp_data = {32'd5, 32'd0, 32'd7, 32'd21};
    #12;
    checkOutput("rst_busy", m_busy, 0);
    checkOutput("rst_done", m_done, 0);
    checkOutput("rst_cycles", m_cyc, 0);
    arst_n = 1'b1;
    tick(2);

    $display("[TB] pass path");
    pulseStart(0);
    checkOutput("run_busy", m_busy, 1);
    applyStimulus(10'd321, 32'd21);
    applyStimulus(10'd322, 32'd7);
    applyStimulus(10'd323, 32'd0);
    applyStimulus(10'd324, 32'd5);
    applyStimulus(10'd100, 32'd77);
    tick(95);
    checkOutput("cyc_before_flag", m_cyc, 100);
    applyStimulus(10'd320, 32'd1);
    checkOutput("check_busy", m_busy, 1);
    applyStimulus(10'd321, 32'd55);
    tick(2);
    checkOutput("check_lat_busy", m_busy, 1);
    checkOutput("check_lat_done", m_done, 0);
    tick(1);
    checkOutput("pass_pass", m_pass, 1);
    checkOutput("pass_done", m_done, 1);
    checkOutput("pass_busy", m_busy, 0);
    checkOutput("pass_cycles", m_cyc, 100);
    checkOutput("pass_res0", m_res0, 21);
    checkOutput("pass_fidx", m_fidx, 0);

    $display("[TB] mismatch at word 2");
    pulseStart(0);
    applyStimulus(10'd321, 32'd21);
    applyStimulus(10'd322, 32'd7);
    applyStimulus(10'd323, 32'd9);
    applyStimulus(10'd324, 32'd5);
    applyStimulus(10'd320, 32'd1);
    tick(2);
    checkOutput("mm2_busy", m_busy, 1);
    tick(1);
    checkOutput("mm2_done", m_done, 1);
    checkOutput("mm2_pass", m_pass, 0);
    checkOutput("mm2_fidx", m_fidx, 2);

    $display("[TB] word 3 never written");
    pulseStart(0);
    checkOutput("rerun_fidx_clr", m_fidx, 0);
    applyStimulus(10'd321, 32'd21);
    applyStimulus(10'd322, 32'd7);
    applyStimulus(10'd323, 32'd0);
    applyStimulus(10'd320, 32'd1);
    tick(3);
    checkOutput("mm3_busy", m_busy, 1);
    tick(1);
    checkOutput("mm3_done", m_done, 1);
    checkOutput("mm3_fidx", m_fidx, 3);

    $display("[TB] flag filter, overwrite, start ignored in run");
    pulseStart(0);
    applyStimulus(10'd321, 32'd3);
    applyStimulus(10'd320, 32'd2);
    tick(3);
    checkOutput("flag2_busy", m_busy, 1);
    checkOutput("flag2_done", m_done, 0);
    checkOutput("ovw_first", m_res0, 3);
    pulseStart(0);
    applyStimulus(10'd321, 32'd21);
    applyStimulus(10'd322, 32'd7);
    applyStimulus(10'd323, 32'd0);
    applyStimulus(10'd324, 32'd5);
    applyStimulus(10'd320, 32'd1);
    checkOutput("ign_start_cycles", m_cyc, 10);
    checkOutput("ovw_res0", m_res0, 21);
    tick(4);
    checkOutput("ovw_pass", m_pass, 1);

    $display("[TB] restart from pass, then reset mid-run");
    pulseStart(0);
    checkOutput("restart_done", m_done, 0);
    checkOutput("restart_pass", m_pass, 0);
    checkOutput("restart_cycles", m_cyc, 0);
    checkOutput("restart_res0", m_res0, 0);
    applyStimulus(10'd321, 32'd21);
    checkOutput("prerst_res0", m_res0, 21);
    arst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", m_busy, 0);
    checkOutput("midrst_res0", m_res0, 0);
    checkOutput("midrst_cycles", m_cyc, 0);
    arst_n = 1'b1;
    tick(1);
    checkOutput("postrst_idle", m_busy, 0);
    pulseStart(0);
    applyStimulus(10'd322, 32'd7);
    applyStimulus(10'd323, 32'd0);
    applyStimulus(10'd324, 32'd5);
    applyStimulus(10'd320, 32'd1);
    tick(1);
    checkOutput("indep_done", m_done, 1);
    checkOutput("indep_pass", m_pass, 0);
    checkOutput("indep_fidx", m_fidx, 0);

    $display("[TB] timeout boundary");
    pulseStart(1);
    tick(49);
    checkOutput("tout49_busy", t_busy, 1);
    checkOutput("tout49_tout", t_tout, 0);
    checkOutput("tout49_cycles", t_cyc, 49);
    tick(1);
    checkOutput("tout_tout", t_tout, 1);
    checkOutput("tout_done", t_done, 1);
    checkOutput("tout_busy", t_busy, 0);
    checkOutput("tout_pass", t_pass, 0);
    pulseStart(1);
    checkOutput("tout_clr", t_tout, 0);
    tick(49);
    applyStimulus(10'd320, 32'd1);
    checkOutput("flag49_busy", t_busy, 1);
    checkOutput("flag49_tout", t_tout, 0);
    tick(1);
    checkOutput("flag49_fail", t_done, 1);
    checkOutput("flag49_nott", t_tout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
